// File: rtl/dmem.sv
// Data memory: DEPTH words of DATA_WIDTH bits, word-addressed from a byte address.
// Registered read with one clock of latency. A write also shows its data on
// read_data at the same edge (write-through). rst clears only the read
// register; memory contents survive reset.
module dmem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wr,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int IDX_W = $clog2(DEPTH);

    // Storage powers up cleared, so never-written words read back as zero.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [IDX_W-1:0]      w_index;
    logic                  w_unused_addr;

    // The byte-lane bits and the bits above the index field play no part in
    // addressing, so addresses alias modulo DEPTH*4 bytes.
    assign w_index       = addr[IDX_W+1:2];
    assign w_unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

    // Memory array write; rst is sampled here so a write racing reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            r_mem[w_index] <= write_data;
        end
    end

    // Read register: cleared at once by rst, else loads write-through or stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= {DATA_WIDTH{1'b0}};
        end else if (mem_wr) begin
            r_read_data <= write_data;
        end else begin
            r_read_data <= r_mem[w_index];
        end
    end

    assign read_data = r_read_data;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem: write-through, persistence, overwrite,
// aliasing, never-written words, and asynchronous reset behaviour.
module tb_dmem;

    logic        clk;
    logic        rst;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int n_checks;
    int n_fail;

    dmem #(
        .DATA_WIDTH(32),
        .DEPTH     (256)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .write_data(write_data),
        .read_data (read_data)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one access at the falling edge, let the rising edge act, sample 1 ns later.
    task automatic do_cycle(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_wr     = wr;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        mem_wr     = 1'b0;
        addr       = 32'h0000_0000;
        write_data = 32'h0000_0000;

        #1;
        check_value("reset_state", read_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_value("reset_hold", read_data, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        // Never-written word reads as zero right after reset.
        do_cycle(1'b0, 32'h0000_0000, 32'h1111_1111);
        check_value("fresh_word0", read_data, 32'h0000_0000);

        // Write-through, then read back.
        do_cycle(1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
        check_value("write_through", read_data, 32'hDEAD_BEEF);
        do_cycle(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_value("read_0x000", read_data, 32'hDEAD_BEEF);

        // Persistence across several words.
        do_cycle(1'b1, 32'h0000_0004, 32'h1234_5678);
        check_value("wt_0x004", read_data, 32'h1234_5678);
        do_cycle(1'b1, 32'h0000_0008, 32'hCAFE_BABE);
        check_value("wt_0x008", read_data, 32'hCAFE_BABE);
        do_cycle(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_value("persist_0x000", read_data, 32'hDEAD_BEEF);
        do_cycle(1'b0, 32'h0000_0004, 32'h0000_0000);
        check_value("persist_0x004", read_data, 32'h1234_5678);
        do_cycle(1'b0, 32'h0000_0008, 32'h0000_0000);
        check_value("persist_0x008", read_data, 32'hCAFE_BABE);

        // Output holds between edges even if the address changes.
        @(negedge clk);
        addr = 32'h0000_0004;
        #2;
        check_value("hold_between_edges", read_data, 32'hCAFE_BABE);

        // Overwrite one word, neighbour unaffected.
        do_cycle(1'b1, 32'h0000_0000, 32'hAAAA_AAAA);
        do_cycle(1'b0, 32'h0000_0000, 32'h0000_0000);
        check_value("overwrite_0x000", read_data, 32'hAAAA_AAAA);
        do_cycle(1'b0, 32'h0000_0004, 32'h0000_0000);
        check_value("neighbour_0x004", read_data, 32'h1234_5678);

        // Back-to-back writes, top word, aliasing, untouched word.
        do_cycle(1'b1, 32'h0000_0010, 32'h5555_5555);
        do_cycle(1'b1, 32'h0000_03FC, 32'hFFFF_FFFF);
        do_cycle(1'b0, 32'h0000_0010, 32'h0000_0000);
        check_value("read_0x010", read_data, 32'h5555_5555);
        do_cycle(1'b0, 32'h0000_03FC, 32'h0000_0000);
        check_value("read_0x3FC", read_data, 32'hFFFF_FFFF);
        do_cycle(1'b0, 32'h0000_0403, 32'h0000_0000);
        check_value("alias_0x403", read_data, 32'hAAAA_AAAA);
        do_cycle(1'b0, 32'h0000_0100, 32'h0000_0000);
        check_value("unwritten_0x100", read_data, 32'h0000_0000);
        do_cycle(1'b0, 32'hFFFF_FC12, 32'h0000_0000);
        check_value("alias_high_0x010", read_data, 32'h5555_5555);

        // Reset between edges: immediate clear, write during reset is dropped.
        do_cycle(1'b1, 32'h0000_0020, 32'h9999_9999);
        check_value("wt_0x020", read_data, 32'h9999_9999);
        @(negedge clk);
        mem_wr     = 1'b1;
        addr       = 32'h0000_0024;
        write_data = 32'h7777_7777;
        #1;
        rst = 1'b1;
        #1;
        check_value("rst_async_clear", read_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_value("rst_hold_on_write", read_data, 32'h0000_0000);
        @(negedge clk);
        rst    = 1'b0;
        mem_wr = 1'b0;

        do_cycle(1'b0, 32'h0000_0020, 32'h0000_0000);
        check_value("after_rst_0x020", read_data, 32'h9999_9999);
        do_cycle(1'b0, 32'h0000_0024, 32'h0000_0000);
        check_value("suppressed_0x024", read_data, 32'h0000_0000);
        do_cycle(1'b0, 32'h0000_0008, 32'h0000_0000);
        check_value("after_rst_0x008", read_data, 32'hCAFE_BABE);

        // First edge after reset performs a normal write.
        do_cycle(1'b1, 32'h0000_0024, 32'h0BAD_F00D);
        check_value("post_rst_write", read_data, 32'h0BAD_F00D);
        do_cycle(1'b0, 32'h0000_0024, 32'h0000_0000);
        check_value("post_rst_read", read_data, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; all data ports use this width.
REQ-002 Parameter DEPTH, default 256: number of words stored; power of two; word index width = log2(DEPTH) (8 at default).
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port mem_wr  input  1: write enable, sampled at rising clk.
REQ-006 Port addr  input  32: byte address; word index = addr[log2(DEPTH)+1:2] (addr[9:2] at default).
REQ-007 Port write_data  input  DATA_WIDTH: data written when mem_wr=1.
REQ-008 Port read_data  output  DATA_WIDTH: registered read data.

Function
REQ-009 Storage SHALL be DEPTH words of DATA_WIDTH bits, word-addressed.
REQ-010 addr[1:0] SHALL be ignored; no byte/halfword access, no misalignment error.
REQ-011 addr bits above the index field SHALL be ignored; addresses alias modulo DEPTH*4 bytes (0x400 at default).
REQ-012 Write: at rising clk with rst=0 and mem_wr=1, mem[index] <= write_data; visible to reads from the next edge.
REQ-013 Read: at every rising clk with rst=0, read_data <= mem[index]; read latency exactly 1 clock, independent of mem_wr.
REQ-014 Read-during-write (mem_wr=1): read_data SHALL load write_data (write-through) in that same edge.
REQ-015 read_data SHALL hold its value between rising edges; no combinational path from addr to read_data.
REQ-016 Back-to-back writes to different words on consecutive cycles SHALL all be retained.
REQ-017 Overwriting a word SHALL replace it fully; other words unaffected.
REQ-018 All memory words SHALL power up (simulation time 0) as zero; reading a never-written word returns 0x00000000.
REQ-019 No other outputs, status flags or error signals.

Reset
REQ-020 rst=1 SHALL immediately (asynchronously) force read_data to 0x00000000 and hold it while asserted.
REQ-021 While rst=1, writes SHALL be suppressed: mem_wr ignored, memory contents unchanged.
REQ-022 Reset SHALL NOT clear memory contents; data written before reset remain readable after it.
REQ-023 After rst deasserts, the first rising clk performs a normal read/write per REQ-012..014.
REQ-024 Reset asserted mid-write (same cycle as mem_wr=1, before the edge) SHALL cancel that write.

Verification
REQ-025 Write 0xDEADBEEF to 0x000, then mem_wr=0 same addr -> read_data=0xDEADBEEF one edge after the read edge; write edge itself shows 0xDEADBEEF (write-through).
REQ-026 Write 0x12345678 @0x004, 0xCAFEBABE @0x008, then read 0x000, 0x004, 0x008 -> 0xDEADBEEF, 0x12345678, 0xCAFEBABE (persistence, 1-cycle latency each).
REQ-027 Overwrite 0x000 with 0xAAAAAAAA -> read 0x000 = 0xAAAAAAAA, 0x004 still 0x12345678.
REQ-028 Write 0x55555555 @0x010 (mem[4]) and 0xFFFFFFFF @0x3FC (mem[255]); read both back; read 0x403 -> 0xDEADBEEF-or-current mem[0] (alias + ignored low bits); read 0x100 never written -> 0x00000000.
REQ-029 Write 0x99999999 @0x020, pulse rst=1 between clock edges -> read_data 0 immediately; write attempted during rst @0x024 not stored; after release read 0x020 = 0x99999999, 0x024 = 0x00000000.
